// File: rtl/bitmask_encoder_seq_if.sv
// bitmask_encoder_seq_if: handshake bundle between a mask producer, the encoder and an index consumer
interface bitmask_encoder_seq_if #(
    parameter int N = 16,
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         zero_drop;
    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, zero_drop
    );
    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, zero_drop
    );
endinterface

// File: rtl/bitmask_encoder_seq.sv
// bitmask_encoder_seq: streams the index of every set bit of an accepted mask, lowest first
module bitmask_encoder_seq #(
    parameter int N = 16,
    parameter int W = 4
) (
    input logic                   clk,
    input logic                   rst,
    bitmask_encoder_seq_if.slave  bus
);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic         zero_drop_q, zero_drop_d;
    logic [W-1:0] idx;
    logic         in_ready, out_valid, out_last, accept, beat;
    // lowest set bit of the pending mask; scanning downward lets the lowest hit win
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (pending_q[i]) idx = W'(i);
    end
    // handshake decode, next pending mask and next state
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        zero_drop_d = 1'b0;
        in_ready    = (state_q == IDLE) & ~rst;
        out_valid   = (state_q == EMIT) & ~rst;
        out_last    = out_valid & (pending_q != '0) & ((pending_q & (pending_q - 1'b1)) == '0);
        accept      = bus.in_valid & in_ready;
        beat        = out_valid & bus.out_ready;
        if (accept) begin
            zero_drop_d = (bus.in_vec == '0);
            pending_d   = bus.in_vec;
            state_d     = (bus.in_vec == '0) ? IDLE : EMIT;
        end
        if (beat) begin
            pending_d = pending_q & ~(N'(1) << idx);
            state_d   = out_last ? IDLE : EMIT;
        end
    end
    // state, pending mask and the registered zero-drop pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            zero_drop_q <= zero_drop_d;
        end
    end
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_idx   = idx;
    assign bus.out_last  = out_last;
    assign bus.zero_drop = zero_drop_q;
endmodule

// File: tb/tb_bitmask_encoder_seq.sv
// tb_bitmask_encoder_seq: table, directed and random checks against a queue-based index model
module tb_bitmask_encoder_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bitmask_encoder_seq_if bus ();
    bitmask_encoder_seq dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] vec;
        int          cnt;
        int          first;
        int          lst;
    } vec_t;

    int         nvec = 0;
    int         errs = 0;
    logic [3:0] q[$];
    int         seen[$];
    logic       zd = 1'b0;
    logic       acc, beat;
    vec_t       tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // one clock cycle: drive, check outputs against the model, advance the model across the edge
    task automatic step(input logic r, input logic iv, input logic [15:0] v, input logic ordy);
        logic er, eo;
        @(negedge clk);
        rst = r;
        bus.in_valid = iv;
        bus.in_vec = v;
        bus.out_ready = ordy;
        #1;
        er = (q.size() == 0) && !r;
        eo = (q.size() != 0) && !r;
        chk("in_ready", int'(bus.in_ready), int'(er));
        chk("out_valid", int'(bus.out_valid), int'(eo));
        chk("zero_drop", int'(bus.zero_drop), int'(zd));
        if (eo) begin
            chk("out_idx", int'(bus.out_idx), int'(q[0]));
            chk("out_last", int'(bus.out_last), int'(q.size() == 1));
        end else chk("out_last_idle", int'(bus.out_last), 0);
        acc = er && iv;
        beat = eo && ordy;
        if (beat) seen.push_back(int'(bus.out_idx));
        if (r) begin
            q.delete();
            zd = 1'b0;
        end else begin
            zd = acc && (v == 16'h0);
            if (acc) for (int i = 0; i < 16; i++) if (v[i]) q.push_back(4'(i));
            if (beat) void'(q.pop_front());
        end
    endtask

    // present a vector until accepted, then drain it; rnd randomizes out_ready and noise on in_valid
    task automatic run_vec(input logic [15:0] v, input bit rnd);
        int n = 0;
        seen.delete();
        acc = 1'b0;
        while (!acc && n < 64) begin
            step(1'b0, 1'b1, v, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        while (q.size() != 0 && n < 64) begin
            step(1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b0, 16'($urandom), rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        if (n >= 64) chk("timeout", n, 0);
    endtask

    initial begin
        tbl[0] = '{16'h0001, 1, 0, 0};
        tbl[1] = '{16'h8421, 4, 0, 15};
        tbl[2] = '{16'hFFFF, 16, 0, 15};
        tbl[3] = '{16'h8000, 1, 15, 15};
        tbl[4] = '{16'h00F0, 4, 4, 7};
        tbl[5] = '{16'h0300, 2, 8, 9};
        tbl[6] = '{16'hAAAA, 8, 1, 15};
        tbl[7] = '{16'h0006, 2, 1, 2};
        bus.in_valid = 1'b0;
        bus.in_vec = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        step(1'b1, 1'b1, 16'h1234, 1'b1);
        // test 1: single bit
        run_vec(16'h0001, 1'b0);
        chk("t1_beats", seen.size(), 1);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t1_ready_after", int'(bus.in_ready), 1);
        // table-driven vectors at full throughput
        for (int k = 0; k < 8; k++) begin
            run_vec(tbl[k].vec, 1'b0);
            chk("tbl_count", seen.size(), tbl[k].cnt);
            if (seen.size() != 0) begin
                chk("tbl_first", seen[0], tbl[k].first);
                chk("tbl_last", seen[seen.size() - 1], tbl[k].lst);
            end
        end
        // test 3: back-pressure holds idx 8 stable
        seen.delete();
        step(1'b0, 1'b1, 16'h0300, 1'b0);
        repeat (3) begin
            step(1'b0, 1'b1, 16'hFFFF, 1'b0);
            chk("t3_hold_idx", int'(bus.out_idx), 8);
            chk("t3_hold_last", int'(bus.out_last), 0);
        end
        step(1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t3_last_idx", int'(bus.out_idx), 9);
        chk("t3_last_flag", int'(bus.out_last), 1);
        // test 4: zero vector is dropped with a single-cycle pulse
        step(1'b0, 1'b1, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("t4_pulse", int'(bus.zero_drop), 1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("t4_pulse_end", int'(bus.zero_drop), 0);
        // test 5: all ones with random back-pressure
        run_vec(16'hFFFF, 1'b1);
        chk("t5_beats", seen.size(), 16);
        for (int i = 0; i < seen.size(); i++) chk("t5_order", seen[i], i);
        // test 6: reset mid-emit discards 6 and 7
        seen.delete();
        step(1'b0, 1'b1, 16'h00F0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b1, 1'b0, 16'h0, 1'b1);
        chk("t6_valid_in_rst", int'(bus.out_valid), 0);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t6_idle_ready", int'(bus.in_ready), 1);
        chk("t6_beats", seen.size(), 2);
        // reset coincident with an offered vector: nothing captured
        step(1'b1, 1'b1, 16'h0F00, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        chk("rst_accept_valid", int'(bus.out_valid), 0);
        // random masks of varied density
        for (int k = 0; k < 40; k++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if (k % 3 == 0) v = v & 16'($urandom);
            if (k % 5 == 0) v = v & 16'($urandom) & 16'($urandom);
            run_vec(v, 1'b1);
            chk("rnd_count", seen.size(), $countones(v));
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
